k_nearest_select: RTL and testbench
===================================

// Module: k_nearest_select
// PURPOSE
//   Upstream producer of the k_type interface. Accepts a stream of up to N training-sample
//   results (distance, type), one per cycle, and keeps a sorted list of the K smallest
//   distances by shift-insertion. After the last sample it presents the K types with a
//   one-cycle valid_sort pulse, then holds them until k_type returns inference_done.
// PARAMETERS
//   N       10  max samples per query; a counter wraps the query at N
//   W       32  distance width, unsigned
//   K        5  neighbours kept, 1 <= K <= N
//   TYPE_W   4  class/type label width
// PORTS
//   clk                       in   1         single clock, all logic on rising edge
//   rst                       in   1         synchronous, active-high reset
//   sample_valid              in   1         distance_in/type_in valid this cycle
//   sample_ready              out  1         block accepts a sample (high only in COLLECT)
//   sample_last               in   1         qualifies the final sample of the query
//   distance_in               in   W         unsigned distance of the sample
//   type_in                   in   TYPE_W    type label of the sample
//   valid_sort                out  1         one-cycle pulse: neighbour list complete
//   k_nearest_neighbours_type out  K*TYPE_W  slot i = [i*TYPE_W +: TYPE_W], slot 0 nearest
//   inference_done            in   1         from k_type; releases the held list
//   short_query               out  1         query ended with fewer than K samples
// BEHAVIOUR
//   - Reset: state=COLLECT, sample_ready=1, valid_sort=0, short_query=0, all type slots=0,
//     all distance slots=all-ones, sample count=0. Reset mid-query discards everything.
//   - FSM: COLLECT -> EMIT -> WAIT_DONE -> COLLECT.
//   - COLLECT: sample accepted on edge where sample_valid & sample_ready. Insertion: find
//     first slot j with distance_in < dist[j] (strict); slots j..K-2 shift to j+1, slot
//     K-1 drops, slot j loads (distance_in, type_in). No such j -> sample discarded.
//     Ties keep the earlier sample ahead (stable). One insertion per cycle, no bubbles.
//   - Count increments per accepted sample; accepted sample with sample_last=1 or count
//     reaching N -> EMIT next cycle. sample_last without sample_valid is ignored.
//   - EMIT: valid_sort=1 for exactly one cycle, sample_ready=0, list stable; short_query=1
//     if count < K (unfilled slots keep type 0). Then WAIT_DONE.
//   - Latency: last sample accepted at edge t -> valid_sort high in cycle t+1.
//   - WAIT_DONE: sample_ready=0, list and short_query held. Edge sampling inference_done=1
//     -> COLLECT with slots, count and short_query cleared in that same edge.
//   - inference_done high in COLLECT or EMIT is ignored (no state change, no clear).
//   - Outputs k_nearest_neighbours_type are registered slot contents, valid any time but
//     only meaningful from valid_sort until inference_done.
//   - Distance compare purely unsigned W-bit; all-ones distance never inserts into an
//     empty slot (strict <), so it counts but its type is not kept.
// CONFIGURATION
//   KNN_DIST_OUT_EN defined: adds output k_nearest_distances [K*W-1:0], slot i at
//     [i*W +: W], same timing/hold rules as the type slots; reset value all-ones.
//   Not defined: port absent; distance registers internal only, behaviour otherwise identical.
// TESTING (N=10, K=5, TYPE_W=4, W=32)
//   - Distances 9,3,7,1,5,8,2,6,4,0 types 0..9, last on 10th -> valid_sort 1 cycle after;
//     types {9,3,6,1,8}; short_query=0.
//   - Ties: distances 4,4,4,4,4,4 types 1..6, last on 6th -> types {1,2,3,4,5}.
//   - Short query: 3 samples d=5,2,9 types 7,8,9 last -> types {8,7,9,0,0}, short_query=1.
//   - No sample_last: 10 samples accepted -> EMIT after 10th; sample_ready=0 until
//     inference_done; 11th sample held off; inference_done early in COLLECT has no effect.
//   - Handshake: hold inference_done=0 for 20 cycles -> list stable, valid_sort not
//     repeated; pulse inference_done -> next cycle sample_ready=1, slots cleared.
//   - rst asserted mid-query after 4 samples -> next cycle all outputs at reset values,
//     fresh query of 5 samples yields only those 5 types.

Source files
------------

// File: rtl/k_nearest_select_if.sv
// k_nearest_select_if: bundles the sample stream and the neighbour-list handshake.
//   master : k_nearest_select side (consumes samples, produces the neighbour list)
//   slave  : producer of samples / k_type consumer side
// Signals: sample_valid/ready/last, distance_in, type_in, valid_sort,
//   k_nearest_neighbours_type, inference_done, short_query,
//   k_nearest_distances (only when KNN_DIST_OUT_EN is defined).
interface k_nearest_select_if #(
    parameter int unsigned W      = 32,
    parameter int unsigned K      = 5,
    parameter int unsigned TYPE_W = 4
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  sample_last;
    logic [W-1:0]          distance_in;
    logic [TYPE_W-1:0]     type_in;
    logic                  valid_sort;
    logic [K*TYPE_W-1:0]   k_nearest_neighbours_type;
    logic                  inference_done;
    logic                  short_query;
`ifdef KNN_DIST_OUT_EN
    logic [K*W-1:0]        k_nearest_distances;

    modport master (
        input  sample_valid, sample_last, distance_in, type_in, inference_done,
        output sample_ready, valid_sort, k_nearest_neighbours_type, short_query,
               k_nearest_distances
    );
    modport slave (
        output sample_valid, sample_last, distance_in, type_in, inference_done,
        input  sample_ready, valid_sort, k_nearest_neighbours_type, short_query,
               k_nearest_distances
    );
`else
    modport master (
        input  sample_valid, sample_last, distance_in, type_in, inference_done,
        output sample_ready, valid_sort, k_nearest_neighbours_type, short_query
    );
    modport slave (
        output sample_valid, sample_last, distance_in, type_in, inference_done,
        input  sample_ready, valid_sort, k_nearest_neighbours_type, short_query
    );
`endif
endinterface

// File: rtl/k_nearest_select.sv
// k_nearest_select: keeps the K smallest (distance, type) pairs of a query of up
// to N samples via shift-insertion, pulses valid_sort once the query ends and
// holds the list until inference_done.
// Ports: clk, rst (synchronous, active-high), bus (k_nearest_select_if.master).
// Optional macro KNN_DIST_OUT_EN exposes the sorted distance slots on
// bus.k_nearest_distances.
module k_nearest_select #(
    parameter int unsigned N      = 10,
    parameter int unsigned W      = 32,
    parameter int unsigned K      = 5,
    parameter int unsigned TYPE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    k_nearest_select_if.master bus
);
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        EMIT      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [K-1:0][W-1:0]       dist_q, dist_d;
    logic [K-1:0][TYPE_W-1:0]  type_q, type_d;
    logic [CNT_W-1:0]          count_q, count_d, count_inc;
    logic                      short_q, short_d;
    logic                      ready_q, valid_q;
    logic [K-1:0]              lt;

    // Per-slot strict compare; the list is sorted, so lt is monotone (0..0 1..1).
    always_comb begin
        for (int i = 0; i < K; i++) begin
            lt[i] = bus.distance_in < dist_q[i];
        end
    end

    assign count_inc = count_q + CNT_W'(1);

    // Next-state, insertion and clear logic.
    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        type_d  = type_q;
        count_d = count_q;
        short_d = short_q;
        case (state_q)
            COLLECT: begin
                if (bus.sample_valid) begin
                    count_d = count_inc;
                    // Slot 0 loads on any hit; others shift from below if the
                    // slot below also hit, else they are the first hit and load.
                    if (lt[0]) begin
                        dist_d[0] = bus.distance_in;
                        type_d[0] = bus.type_in;
                    end
                    for (int i = 1; i < K; i++) begin
                        if (lt[i]) begin
                            if (lt[i-1]) begin
                                dist_d[i] = dist_q[i-1];
                                type_d[i] = type_q[i-1];
                            end else begin
                                dist_d[i] = bus.distance_in;
                                type_d[i] = bus.type_in;
                            end
                        end
                    end
                    if (bus.sample_last || (count_inc == CNT_W'(N))) begin
                        state_d = EMIT;
                        short_d = count_inc < CNT_W'(K);
                    end
                end
            end
            EMIT: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.inference_done) begin
                    state_d = COLLECT;
                    dist_d  = '1;
                    type_d  = '0;
                    count_d = '0;
                    short_d = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers; handshake outputs registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            dist_q  <= '1;
            type_q  <= '0;
            count_q <= '0;
            short_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dist_q  <= dist_d;
            type_q  <= type_d;
            count_q <= count_d;
            short_q <= short_d;
            ready_q <= (state_d == COLLECT);
            valid_q <= (state_d == EMIT);
        end
    end

    assign bus.sample_ready              = ready_q;
    assign bus.valid_sort                = valid_q;
    assign bus.short_query               = short_q;
    assign bus.k_nearest_neighbours_type = type_q;
`ifdef KNN_DIST_OUT_EN
    assign bus.k_nearest_distances       = dist_q;
`else
    // Distance slots stay internal.
`endif
endmodule

// File: tb/tb_k_nearest_select.sv
// tb_k_nearest_select: directed self-checking bench for k_nearest_select
// (N=10, W=32, K=5, TYPE_W=4). Inputs change and outputs are checked at negedge.
module tb_k_nearest_select;
    localparam int unsigned N      = 10;
    localparam int unsigned W      = 32;
    localparam int unsigned K      = 5;
    localparam int unsigned TYPE_W = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [K*TYPE_W-1:0] held;

    k_nearest_select_if #(.W(W), .K(K), .TYPE_W(TYPE_W)) bus ();

    k_nearest_select #(.N(N), .W(W), .K(K), .TYPE_W(TYPE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [K*TYPE_W-1:0] pk(input int t0, input int t1, input int t2,
                                               input int t3, input int t4);
        return {4'(t4), 4'(t3), 4'(t2), 4'(t1), 4'(t0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample for one cycle (call at negedge; returns at next negedge).
    task automatic send(input logic [W-1:0] d, input int t, input logic last);
        bus.sample_valid = 1'b1;
        bus.distance_in  = d;
        bus.type_in      = 4'(t);
        bus.sample_last  = last;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sample_last  = 1'b0;
    endtask

    task automatic pulse_done();
        bus.inference_done = 1'b1;
        @(negedge clk);
        bus.inference_done = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(bus.sample_ready), 32'd1);
        check({tag, "_valid"}, 32'(bus.valid_sort), 32'd0);
        check({tag, "_short"}, 32'(bus.short_query), 32'd0);
        check({tag, "_types"}, 32'(bus.k_nearest_neighbours_type), 32'd0);
    endtask

    task automatic check_emit(input string tag, input logic [K*TYPE_W-1:0] exp_t,
                              input logic exp_short);
        check({tag, "_valid"}, 32'(bus.valid_sort), 32'd1);
        check({tag, "_ready"}, 32'(bus.sample_ready), 32'd0);
        check({tag, "_types"}, 32'(bus.k_nearest_neighbours_type), 32'(exp_t));
        check({tag, "_short"}, 32'(bus.short_query), 32'(exp_short));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.sample_valid   = 1'b0;
        bus.sample_last    = 1'b0;
        bus.distance_in    = '0;
        bus.type_in        = '0;
        bus.inference_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full query with sample_last on the 10th sample.
        send(32'd9, 0, 1'b0); send(32'd3, 1, 1'b0); send(32'd7, 2, 1'b0);
        send(32'd1, 3, 1'b0); send(32'd5, 4, 1'b0); send(32'd8, 5, 1'b0);
        send(32'd2, 6, 1'b0); send(32'd6, 7, 1'b0); send(32'd4, 8, 1'b0);
        send(32'd0, 9, 1'b1);
        check_emit("q1", pk(9, 3, 6, 1, 8), 1'b0);
        @(negedge clk);
        check("q1_pulse_end", 32'(bus.valid_sort), 32'd0);
        check("q1_hold", 32'(bus.k_nearest_neighbours_type), 32'(pk(9, 3, 6, 1, 8)));
        pulse_done();
        check_idle("q1_clr");

        // Equal distances keep arrival order.
        for (int i = 1; i <= 6; i++) send(32'd4, i, (i == 6));
        check_emit("tie", pk(1, 2, 3, 4, 5), 1'b0);
        @(negedge clk);
        pulse_done();
        check_idle("tie_clr");

        // Short query, then a long hold without inference_done.
        send(32'd5, 7, 1'b0); send(32'd2, 8, 1'b0); send(32'd9, 9, 1'b1);
        check_emit("short", pk(8, 7, 9, 0, 0), 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.valid_sort), 32'd0);
            check("hold_ready", 32'(bus.sample_ready), 32'd0);
            check("hold_types", 32'(bus.k_nearest_neighbours_type), 32'(pk(8, 7, 9, 0, 0)));
            check("hold_short", 32'(bus.short_query), 32'd1);
        end
        pulse_done();
        check_idle("short_clr");

        // Count wrap at N without sample_last; early inference_done is ignored.
        bus.inference_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.inference_done = 1'b0;
            send(32'(100 - 10 * i), i, 1'b0);
        end
        check_emit("wrap", pk(9, 8, 7, 6, 5), 1'b0);
        held = bus.k_nearest_neighbours_type;
        // An 11th sample must be held off.
        bus.sample_valid = 1'b1;
        bus.distance_in  = 32'd1;
        bus.type_in      = 4'd15;
        bus.sample_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("held_off_ready", 32'(bus.sample_ready), 32'd0);
            check("held_off_types", 32'(bus.k_nearest_neighbours_type), 32'(held));
        end
        bus.sample_valid = 1'b0;
        bus.sample_last  = 1'b0;
        pulse_done();
        check_idle("wrap_clr");

        // All-ones distance counts but never enters a slot.
        send(32'hFFFF_FFFF, 5, 1'b1);
        check_emit("allones", pk(0, 0, 0, 0, 0), 1'b1);
        @(negedge clk);
        pulse_done();
        check_idle("allones_clr");

        // Reset mid-query discards the partial list.
        send(32'd1, 1, 1'b0); send(32'd2, 2, 1'b0);
        send(32'd3, 3, 1'b0); send(32'd4, 4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        send(32'd50, 11, 1'b0); send(32'd40, 12, 1'b0); send(32'd30, 13, 1'b0);
        send(32'd20, 14, 1'b0); send(32'd10, 15, 1'b1);
        check_emit("post_rst", pk(15, 14, 13, 12, 11), 1'b0);
        @(negedge clk);
        pulse_done();
        check_idle("post_rst_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
